// File: rtl/mm_pkg.sv
// Shared types and constants for the mm_responder line-granular memory model.
package mm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } mm_state_t;

   localparam int MM_LINE_BITS   = 256;
   localparam int MM_OFFSET_BITS = 5;

   // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
   localparam logic [15:0] MM_LFSR_SEED = 16'hACE1;
   localparam logic [15:0] MM_LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] mm_lfsr_next(input logic [15:0] s);
      return {s[14:0], ^(s & MM_LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/mm_line_ram.sv
// Single-port line store: synchronous write, registered read with enable.
// Only the read register is reset; the array contents never are.
module mm_line_ram
   import mm_pkg::*;
#(
   parameter int ADDR_WIDTH = 16
)
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_we,
   input  logic                    i_re,
   input  logic [ADDR_WIDTH-1:0]   i_addr,
   input  logic [MM_LINE_BITS-1:0] i_wd,
   output logic [MM_LINE_BITS-1:0] o_rd
);

   logic [MM_LINE_BITS-1:0] r_mem [0:(1 << ADDR_WIDTH) - 1];
   logic [MM_LINE_BITS-1:0] r_rd;

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wd;
      end
   end

   // The read register doubles as the responder's mm_rd, so it holds between reads.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd <= '0;
      end else if (i_re) begin
         r_rd <= r_mem[i_addr];
      end
   end

   assign o_rd = r_rd;

endmodule

// File: rtl/mm_responder.sv
// Main-memory responder: one line fill/eviction at a time, done after a programmable latency.
// Define MM_RANDOM_LATENCY_EN to add 0..7 LFSR-driven extra cycles per request.
module mm_responder
   import mm_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int LATENCY    = 4
)
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic [31:0]             mm_a,
   input  logic                    mm_read,
   input  logic                    mm_write,
   input  logic [MM_LINE_BITS-1:0] mm_wd,
   output logic [MM_LINE_BITS-1:0] mm_rd,
   output logic                    mm_valid,
   output logic                    mm_busy,
   output logic                    mm_err
);

`ifdef MM_RANDOM_LATENCY_EN
   localparam int CNT_W = 5;
`else
   localparam int CNT_W = 4;
`endif

   if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $fatal(1, "mm_responder: LATENCY must be in 1..15");
   end

   mm_state_t               r_state;
   mm_state_t               w_state_next;
   logic [CNT_W-1:0]        r_cnt;
   logic [CNT_W-1:0]        w_cnt_next;
   logic [CNT_W-1:0]        w_load;
   logic                    r_is_read;
   logic [ADDR_WIDTH-1:0]   r_line;
   logic [ADDR_WIDTH-1:0]   w_line_in;
   logic [ADDR_WIDTH-1:0]   w_ram_addr;
   logic                    r_valid;
   logic                    r_busy;
   logic                    r_err;
   logic                    w_accept;
   logic                    w_proto_err;
   logic                    w_ram_we;
   logic                    w_ram_re;
   logic                    w_unused_addr;

   // Offset bits and bits above the line index alias onto the same line.
   assign w_line_in     = mm_a[ADDR_WIDTH+MM_OFFSET_BITS-1:MM_OFFSET_BITS];
   assign w_unused_addr = ^mm_a;

`ifdef MM_RANDOM_LATENCY_EN
   logic [15:0] r_lfsr;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_lfsr <= MM_LFSR_SEED;
      end else begin
         r_lfsr <= mm_lfsr_next(r_lfsr);
      end
   end

   assign w_load = CNT_W'(LATENCY - 1) + CNT_W'(r_lfsr[2:0]);
`else
   assign w_load = CNT_W'(LATENCY - 1);
`endif

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_accept     = 1'b0;
      w_proto_err  = 1'b0;
      case (r_state)
         IDLE: begin
            if (mm_read && mm_write) begin
               w_proto_err = 1'b1;
            end else if (mm_read || mm_write) begin
               w_accept     = 1'b1;
               w_cnt_next   = w_load;
               w_state_next = (w_load == '0) ? RESP : WAIT;
            end
         end
         WAIT: begin
            w_cnt_next = r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
               w_state_next = RESP;
            end
         end
         RESP: begin
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // Writes commit at accept; reads land in the RAM register on the edge entering RESP.
   assign w_ram_we   = w_accept && mm_write && !reset;
   assign w_ram_re   = !reset && (w_state_next == RESP) && (r_state != RESP) &&
                       ((r_state == IDLE) ? mm_read : r_is_read);
   assign w_ram_addr = (r_state == IDLE) ? w_line_in : r_line;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_is_read <= 1'b0;
         r_line    <= '0;
         r_valid   <= 1'b0;
         r_busy    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_valid <= (w_state_next == RESP);
         r_busy  <= (w_state_next != IDLE);
         r_err   <= r_err | w_proto_err;
         if (w_accept) begin
            r_is_read <= mm_read;
            r_line    <= w_line_in;
         end
      end
   end

   mm_line_ram #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) store (
      .clk    (clk),
      .reset  (reset),
      .i_we   (w_ram_we),
      .i_re   (w_ram_re),
      .i_addr (w_ram_addr),
      .i_wd   (mm_wd),
      .o_rd   (mm_rd)
   );

   assign mm_valid = r_valid;
   assign mm_busy  = r_busy;
   assign mm_err   = r_err;

endmodule

// File: tb/tb_mm_responder.sv
// Directed bench for mm_responder: a LATENCY=4 instance plus a LATENCY=1 instance for the direct-to-RESP path.
module tb_mm_responder;

   logic         clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset;
   logic [31:0]  mm_a;
   logic         mm_read;
   logic         mm_write;
   logic [255:0] mm_wd;
   logic [255:0] mm_rd;
   logic         mm_valid;
   logic         mm_busy;
   logic         mm_err;

   logic         d1_reset;
   logic [31:0]  d1_a;
   logic         d1_read;
   logic         d1_write;
   logic [255:0] d1_wd;
   logic [255:0] d1_rd;
   logic         d1_valid;
   logic         d1_busy;
   logic         d1_err;

   int n_vec = 0;
   int n_err = 0;

   localparam logic [255:0] DB = {8{32'hDEADBEEF}};
   localparam logic [255:0] V1 = {8{32'h1111_2222}};
   localparam logic [255:0] V2 = {8{32'hCAFE_F00D}};
   localparam logic [255:0] V3 = {4{64'h0F0F_1234_5678_9ABC}};

   logic [255:0] pat;

   mm_responder #(.ADDR_WIDTH(16), .LATENCY(4)) dut (
      .clk(clk), .reset(reset), .mm_a(mm_a), .mm_read(mm_read), .mm_write(mm_write),
      .mm_wd(mm_wd), .mm_rd(mm_rd), .mm_valid(mm_valid), .mm_busy(mm_busy), .mm_err(mm_err)
   );

   mm_responder #(.ADDR_WIDTH(8), .LATENCY(1)) dut1 (
      .clk(clk), .reset(d1_reset), .mm_a(d1_a), .mm_read(d1_read), .mm_write(d1_write),
      .mm_wd(d1_wd), .mm_rd(d1_rd), .mm_valid(d1_valid), .mm_busy(d1_busy), .mm_err(d1_err)
   );

   function automatic logic [255:0] rnd_val(input int i);
      return {8{32'h5A00_0000 | 32'(i)}};
   endfunction

   // Drives one request in its accept cycle only, then waits (bounded) for mm_valid.
   task automatic run_xfer(input logic is_rd, input logic [31:0] a, input logic [255:0] wd,
                           output int lat, output logic [255:0] rd_out);
      @(posedge clk); #1;
      mm_read = is_rd; mm_write = ~is_rd; mm_a = a; mm_wd = wd;
      lat = -1; rd_out = '0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         mm_read = 1'b0; mm_write = 1'b0; mm_a = '0; mm_wd = '0;
         @(negedge clk);
         if (mm_valid) begin
            lat = c; rd_out = mm_rd;
            break;
         end
      end
      $display("xfer %s a=%h lat=%0d", is_rd ? "RD" : "WR", a, lat);
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      #1; reset = 1'b0; d1_reset = 1'b0;
      @(negedge clk);
      n_vec += 6;
      if (mm_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", mm_valid); end
      if (mm_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b exp 0", mm_busy); end
      if (mm_err !== 1'b0) begin n_err++; $display("FAIL rst_err got %b exp 0", mm_err); end
      if (mm_rd !== 256'd0) begin n_err++; $display("FAIL rst_rd got %h exp 0", mm_rd); end
      if (d1_valid !== 1'b0) begin n_err++; $display("FAIL rst_d1_valid got %b exp 0", d1_valid); end
      if (d1_busy !== 1'b0) begin n_err++; $display("FAIL rst_d1_busy got %b exp 0", d1_busy); end
   endtask

   task automatic test_basic_fill;
      int lat;
      logic [255:0] rd;
      logic exp_v, exp_b;
      run_xfer(1'b0, 32'h0000_0200, pat, lat, rd);
      n_vec++;
      if (lat !== 4) begin n_err++; $display("FAIL fill_preload_lat got %0d exp 4", lat); end
      @(posedge clk); #1;
      mm_read = 1'b1; mm_a = 32'h0000_0200;
      for (int c = 0; c <= 6; c++) begin
         @(negedge clk);
         exp_v = (c == 4);
         exp_b = (c >= 1 && c <= 4);
         n_vec += 2;
         if (mm_valid !== exp_v) begin n_err++; $display("FAIL fill_valid c=%0d got %b exp %b", c, mm_valid, exp_v); end
         if (mm_busy !== exp_b) begin n_err++; $display("FAIL fill_busy c=%0d got %b exp %b", c, mm_busy, exp_b); end
         if (c == 4 || c == 6) begin
            n_vec++;
            if (mm_rd !== pat) begin n_err++; $display("FAIL fill_rd c=%0d got %h exp %h", c, mm_rd, pat); end
         end
         @(posedge clk); #1;
         mm_read = 1'b0; mm_a = '0;
      end
   endtask

   task automatic test_write_read;
      int lat;
      logic [255:0] rd;
      run_xfer(1'b0, 32'h0000_0420, DB, lat, rd);
      n_vec += 3;
      if (lat !== 4) begin n_err++; $display("FAIL wr_lat got %0d exp 4", lat); end
      if (rd !== pat) begin n_err++; $display("FAIL wr_rd_hold got %h exp %h", rd, pat); end
      // 0x420 >> 5 is line 0x21.
      if (dut.store.r_mem[33] !== DB) begin n_err++; $display("FAIL wr_store got %h exp %h", dut.store.r_mem[33], DB); end
      // Different offset and an aliased upper bit must hit the same line.
      run_xfer(1'b1, 32'h0020_043F, '0, lat, rd);
      n_vec += 2;
      if (lat !== 4) begin n_err++; $display("FAIL wrrd_lat got %0d exp 4", lat); end
      if (rd !== DB) begin n_err++; $display("FAIL wrrd_data got %h exp %h", rd, DB); end
   endtask

   task automatic test_back_to_back;
      int lat;
      logic [255:0] rd;
      run_xfer(1'b0, 32'h0000_0800, V1, lat, rd);
      n_vec++;
      if (lat !== 4) begin n_err++; $display("FAIL b2b_w1_lat got %0d exp 4", lat); end
      run_xfer(1'b1, 32'h0000_0800, '0, lat, rd);
      n_vec += 2;
      if (lat !== 4) begin n_err++; $display("FAIL b2b_r1_lat got %0d exp 4", lat); end
      if (rd !== V1) begin n_err++; $display("FAIL b2b_r1_data got %h exp %h", rd, V1); end
      run_xfer(1'b0, 32'h0000_0800, V2, lat, rd);
      n_vec++;
      if (lat !== 4) begin n_err++; $display("FAIL b2b_w2_lat got %0d exp 4", lat); end
      run_xfer(1'b1, 32'h0000_0800, '0, lat, rd);
      n_vec += 2;
      if (lat !== 4) begin n_err++; $display("FAIL b2b_r2_lat got %0d exp 4", lat); end
      if (rd !== V2) begin n_err++; $display("FAIL b2b_r2_data got %h exp %h", rd, V2); end
   endtask

   task automatic test_held_cmd;
      logic exp_v, exp_b;
      @(posedge clk); #1;
      mm_read = 1'b1; mm_a = 32'h0000_0200;
      for (int c = 0; c <= 14; c++) begin
         @(negedge clk);
         exp_v = (c == 4 || c == 9 || c == 14);
         exp_b = (c % 5 != 0);
         n_vec += 2;
         if (mm_valid !== exp_v) begin n_err++; $display("FAIL held_valid c=%0d got %b exp %b", c, mm_valid, exp_v); end
         if (mm_busy !== exp_b) begin n_err++; $display("FAIL held_busy c=%0d got %b exp %b", c, mm_busy, exp_b); end
         if (exp_v) begin
            n_vec++;
            if (mm_rd !== pat) begin n_err++; $display("FAIL held_rd c=%0d got %h exp %h", c, mm_rd, pat); end
         end
         @(posedge clk); #1;
         if (c == 14) mm_read = 1'b0;
      end
   endtask

   task automatic test_latency_one;
      logic exp_v;
      @(posedge clk); #1;
      d1_write = 1'b1; d1_a = 32'h0000_0200; d1_wd = ~pat;
      @(negedge clk);
      n_vec++;
      if (d1_valid !== 1'b0) begin n_err++; $display("FAIL l1_wr_c0 got %b exp 0", d1_valid); end
      @(posedge clk); #1;
      d1_write = 1'b0; d1_a = '0; d1_wd = '0;
      @(negedge clk);
      n_vec += 2;
      if (d1_valid !== 1'b1) begin n_err++; $display("FAIL l1_wr_valid got %b exp 1", d1_valid); end
      if (d1_busy !== 1'b1) begin n_err++; $display("FAIL l1_wr_busy got %b exp 1", d1_busy); end
      @(posedge clk); #1;
      d1_read = 1'b1; d1_a = 32'h0000_0200;
      for (int c = 0; c <= 5; c++) begin
         @(negedge clk);
         exp_v = (c % 2 == 1);
         n_vec += 2;
         if (d1_valid !== exp_v) begin n_err++; $display("FAIL l1_valid c=%0d got %b exp %b", c, d1_valid, exp_v); end
         if (d1_busy !== exp_v) begin n_err++; $display("FAIL l1_busy c=%0d got %b exp %b", c, d1_busy, exp_v); end
         if (exp_v) begin
            n_vec++;
            if (d1_rd !== ~pat) begin n_err++; $display("FAIL l1_rd c=%0d got %h exp %h", c, d1_rd, ~pat); end
         end
         @(posedge clk); #1;
         if (c == 5) d1_read = 1'b0;
      end
   endtask

   task automatic test_protocol_err;
      int lat;
      logic [255:0] rd;
      logic exp_e;
      @(posedge clk); #1;
      mm_read = 1'b1; mm_write = 1'b1; mm_a = 32'h0000_0200;
      for (int c = 0; c <= 5; c++) begin
         @(negedge clk);
         exp_e = (c >= 1);
         n_vec += 3;
         if (mm_valid !== 1'b0) begin n_err++; $display("FAIL perr_valid c=%0d got %b exp 0", c, mm_valid); end
         if (mm_busy !== 1'b0) begin n_err++; $display("FAIL perr_busy c=%0d got %b exp 0", c, mm_busy); end
         if (mm_err !== exp_e) begin n_err++; $display("FAIL perr_err c=%0d got %b exp %b", c, mm_err, exp_e); end
         @(posedge clk); #1;
         if (c == 1) begin mm_read = 1'b0; mm_write = 1'b0; end
      end
      run_xfer(1'b1, 32'h0000_0200, '0, lat, rd);
      n_vec += 3;
      if (lat !== 4) begin n_err++; $display("FAIL perr_rd_lat got %0d exp 4", lat); end
      if (rd !== pat) begin n_err++; $display("FAIL perr_rd_data got %h exp %h", rd, pat); end
      if (mm_err !== 1'b1) begin n_err++; $display("FAIL perr_sticky got %b exp 1", mm_err); end
      @(posedge clk); #1; reset = 1'b1;
      @(posedge clk); #1; reset = 1'b0;
      @(negedge clk);
      n_vec++;
      if (mm_err !== 1'b0) begin n_err++; $display("FAIL perr_clear got %b exp 0", mm_err); end
   endtask

   task automatic test_reset_mid;
      int lat;
      logic [255:0] rd;
      logic exp_v;
      @(posedge clk); #1; mm_read = 1'b1; mm_a = 32'h0000_0200;
      @(negedge clk);
      @(posedge clk); #1; mm_read = 1'b0; mm_a = '0;
      @(negedge clk);
      n_vec++;
      if (mm_busy !== 1'b1) begin n_err++; $display("FAIL rmid_busy_c1 got %b exp 1", mm_busy); end
      @(posedge clk); #1; reset = 1'b1;
      @(negedge clk);
      @(posedge clk); #1; reset = 1'b0; mm_read = 1'b1; mm_a = 32'h0000_0800;
      @(negedge clk);
      n_vec += 4;
      if (mm_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid_c3 got %b exp 0", mm_valid); end
      if (mm_busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy_c3 got %b exp 0", mm_busy); end
      if (mm_err !== 1'b0) begin n_err++; $display("FAIL rmid_err_c3 got %b exp 0", mm_err); end
      if (mm_rd !== 256'd0) begin n_err++; $display("FAIL rmid_rd_c3 got %h exp 0", mm_rd); end
      for (int c = 4; c <= 9; c++) begin
         @(posedge clk); #1; mm_read = 1'b0; mm_a = '0;
         @(negedge clk);
         exp_v = (c == 7);
         n_vec++;
         if (mm_valid !== exp_v) begin n_err++; $display("FAIL rmid_valid c=%0d got %b exp %b", c, mm_valid, exp_v); end
         if (c == 7) begin
            n_vec++;
            if (mm_rd !== V2) begin n_err++; $display("FAIL rmid_rd got %h exp %h", mm_rd, V2); end
         end
      end
      // A write survives a reset that arrives after its accept.
      @(posedge clk); #1; mm_write = 1'b1; mm_a = 32'h0000_0C00; mm_wd = V3;
      @(posedge clk); #1; mm_write = 1'b0; mm_a = '0; mm_wd = '0; reset = 1'b1;
      @(posedge clk); #1; reset = 1'b0;
      run_xfer(1'b1, 32'h0000_0C00, '0, lat, rd);
      n_vec += 2;
      if (lat !== 4) begin n_err++; $display("FAIL rmid_wr_lat got %0d exp 4", lat); end
      if (rd !== V3) begin n_err++; $display("FAIL rmid_wr_data got %h exp %h", rd, V3); end
   endtask

`ifdef MM_RANDOM_LATENCY_EN
   task automatic test_random;
      int lat;
      int idx;
      logic [255:0] rd;
      logic [7:0] seen;
      seen = '0;
      for (int i = 0; i < 8; i++) run_xfer(1'b0, 32'(i) << 5, rnd_val(i), lat, rd);
      for (int n = 0; n < 1000; n++) begin
         idx = int'($urandom_range(7));
         run_xfer(1'b1, 32'(idx) << 5, '0, lat, rd);
         n_vec += 2;
         if (lat < 4 || lat > 11) begin n_err++; $display("FAIL rnd_lat n=%0d got %0d exp 4..11", n, lat); end
         else seen[lat-4] = 1'b1;
         if (rd !== rnd_val(idx)) begin n_err++; $display("FAIL rnd_data n=%0d got %h exp %h", n, rd, rnd_val(idx)); end
      end
      n_vec++;
      if (seen !== 8'hFF) begin n_err++; $display("FAIL rnd_cover got %b exp 11111111", seen); end
   endtask
`endif

   initial begin
      reset = 1'b1; mm_a = '0; mm_read = 1'b0; mm_write = 1'b0; mm_wd = '0;
      d1_reset = 1'b1; d1_a = '0; d1_read = 1'b0; d1_write = 1'b0; d1_wd = '0;
      for (int i = 0; i < 32; i++) pat[i*8 +: 8] = 8'(i);
      test_reset;
`ifdef MM_RANDOM_LATENCY_EN
      test_random;
`else
      test_basic_fill;
      test_write_read;
      test_back_to_back;
      test_held_cmd;
      test_latency_one;
      test_protocol_err;
      test_reset_mid;
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
